// File: rtl/act_buf_pkg.sv
// Shared types, default widths and the lane pop-window helper for act_skew_buffer.
package act_buf_pkg;

    localparam int unsigned DEF_IN_DATA_WIDTH = 8;
    localparam int unsigned DEF_ROW           = 8;
    localparam int unsigned DEF_DEPTH         = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        LAST  = 2'd2
    } state_t;

    // A lane pops while the skew counter sits inside [lag, lag+len).
    function automatic logic lane_in_window(input int unsigned lag,
                                            input int unsigned cyc,
                                            input int unsigned len);
        return (cyc >= lag) && (cyc < lag + len);
    endfunction

endpackage

// File: rtl/act_lane_fifo.sv
// Single-lane activation FIFO with registered read data, full/empty flags and occupancy.
module act_lane_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_push,
    input  logic                      i_pop,
    input  logic [DATA_WIDTH-1:0]     i_data,
    output logic [DATA_WIDTH-1:0]     o_data,
    output logic                      o_full,
    output logic                      o_empty,
    output logic [$clog2(DEPTH):0]    o_count
);

    localparam int unsigned PTR_SIZE = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_SIZE-1:0]   r_wptr;
    logic [PTR_SIZE-1:0]   r_rptr;
    logic [PTR_SIZE:0]     r_count;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  w_wr;
    logic                  w_rd;

    assign w_rd = i_pop && !o_empty;
    assign w_wr = i_push && (!o_full || w_rd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_data  <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) begin
                r_data <= r_mem[r_rptr];
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= i_data;
    end

    assign o_data  = r_data;
    assign o_count = r_count;
    assign o_full  = (r_count == (PTR_SIZE+1)'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/act_skew_buffer.sv
// Activation staging buffer: per-row lane FIFOs drained as a diagonally skewed tile.
// Skew is enabled by defining ACT_SKEW_EN; otherwise all lanes drain together.
module act_skew_buffer
    import act_buf_pkg::*;
#(
    parameter int unsigned IN_DATA_WIDTH = DEF_IN_DATA_WIDTH,
    parameter int unsigned ROW           = DEF_ROW,
    parameter int unsigned DEPTH         = DEF_DEPTH,
    parameter int unsigned PTR_SIZE      = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_sel,
    input  logic [IN_DATA_WIDTH*ROW-1:0] in1,
    input  logic [IN_DATA_WIDTH*ROW-1:0] in2,
    input  logic                         start,
    input  logic [PTR_SIZE:0]            tile_len,
    output logic                         start_err,
    output logic [IN_DATA_WIDTH*ROW-1:0] out,
    output logic [ROW-1:0]               out_valid,
    output logic                         busy,
    output logic                         done,
    output logic                         isempty,
    output logic                         isfull
);

    localparam int unsigned CYC_W = $clog2(DEPTH + ROW) + 1;

    state_t                       r_state;
    state_t                       w_state_next;
    logic [CYC_W-1:0]             r_cyc;
    logic [PTR_SIZE:0]            r_len;
    logic                         r_start_err;
    logic [ROW-1:0]               r_out_valid;
    logic [ROW-1:0]               w_pop;
    logic [ROW-1:0]               w_full;
    logic [ROW-1:0]               w_empty;
    logic [ROW-1:0]               w_lane_ok;
    logic [PTR_SIZE:0]            w_count [ROW];
    logic [IN_DATA_WIDTH*ROW-1:0] w_in_word;
    logic [IN_DATA_WIDTH*ROW-1:0] w_fifo_data;
    logic [CYC_W-1:0]             w_end_cyc;
    logic                         w_push;
    logic                         w_range_ok;
    logic                         w_start_ok;
    logic                         w_start_bad;

    assign w_in_word = in_sel ? in2 : in1;
    assign isfull    = |w_full;
    assign isempty   = &w_empty;
    assign in_ready  = !isfull;
    assign w_push    = in_valid && in_ready;

    // Lane 0 always holds the fewest words, so requiring every lane to cover
    // tile_len is the same as checking lane 0 alone.
    assign w_range_ok  = (tile_len != '0) && (tile_len <= (PTR_SIZE+1)'(DEPTH));
    assign w_start_ok  = (r_state == IDLE) && start && w_range_ok && (&w_lane_ok);
    assign w_start_bad = (r_state == IDLE) && start && !(w_range_ok && (&w_lane_ok));

`ifdef ACT_SKEW_EN
    assign w_end_cyc = CYC_W'(r_len) + CYC_W'(ROW) - CYC_W'(2);
`else
    assign w_end_cyc = CYC_W'(r_len) - CYC_W'(1);
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_start_ok) w_state_next = DRAIN;
            DRAIN:   if (r_cyc == w_end_cyc) w_state_next = LAST;
            LAST:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_pop = '0;
        for (int unsigned i = 0; i < ROW; i++) begin
`ifdef ACT_SKEW_EN
            w_pop[i] = (r_state == DRAIN) && lane_in_window(i, 32'(r_cyc), 32'(r_len));
`else
            w_pop[i] = (r_state == DRAIN) && lane_in_window(0, 32'(r_cyc), 32'(r_len));
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cyc       <= '0;
            r_len       <= '0;
            r_start_err <= 1'b0;
            r_out_valid <= '0;
        end else begin
            r_state     <= w_state_next;
            r_start_err <= w_start_bad;
            r_out_valid <= w_pop;
            if (w_start_ok) begin
                r_cyc <= '0;
                r_len <= tile_len;
            end else if (r_state == DRAIN) begin
                r_cyc <= r_cyc + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < ROW; g++) begin : g_lane
        act_lane_fifo #(
            .DATA_WIDTH (IN_DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .i_push  (w_push),
            .i_pop   (w_pop[g]),
            .i_data  (w_in_word[g*IN_DATA_WIDTH +: IN_DATA_WIDTH]),
            .o_data  (w_fifo_data[g*IN_DATA_WIDTH +: IN_DATA_WIDTH]),
            .o_full  (w_full[g]),
            .o_empty (w_empty[g]),
            .o_count (w_count[g])
        );

        assign w_lane_ok[g] = (w_count[g] >= tile_len);
        assign out[g*IN_DATA_WIDTH +: IN_DATA_WIDTH] =
            r_out_valid[g] ? w_fifo_data[g*IN_DATA_WIDTH +: IN_DATA_WIDTH] : '0;
    end

    assign out_valid = r_out_valid;
    assign start_err = r_start_err;
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == LAST);

endmodule
